mtrx_width_conv_fifo: RTL and testbench

//  Parametrised wide-in / narrow-out FIFO feeding systolic-array operand lanes.

---
 rtl/mtrx_fifo_pkg.sv | 27 ++
 rtl/mtrx_dist_ram.sv | 24 ++
 rtl/mtrx_width_conv_fifo.sv | 111 +++++++++++
 tb/tb_mtrx_width_conv_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mtrx_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the width-converting operand FIFO.
package mtrx_fifo_pkg;

   function automatic int calc_ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Index width for an N-entry space; never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit cfg_legal(input int in_w, input int out_w,
                                    input int depth, input int af_thresh);
      bit ok;
      ok = (out_w > 0) && (in_w >= 2 * out_w) && ((in_w % out_w) == 0);
      ok = ok && is_pow2(calc_ratio(in_w, out_w));
      ok = ok && (depth >= 2) && is_pow2(depth);
      ok = ok && (af_thresh >= 1) && (af_thresh <= depth);
      return ok;
   endfunction

endpackage

// File: rtl/mtrx_dist_ram.sv
// DEPTH x W storage with synchronous write and asynchronous read, so the head word
// can be sliced combinationally for first-word-fall-through.
module mtrx_dist_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 64,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mtrx_width_conv_fifo.sv
// Wide-in / narrow-out FWFT FIFO feeding systolic-array operand lanes.
// Define MTRX_FIFO_FILLCNT_EN to expose the stored-word count on fill_cnt.
module mtrx_width_conv_fifo
   import mtrx_fifo_pkg::*;
#(
   parameter int IN_W      = 64,
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int MSB_FIRST = 0
) (
   input  logic                           clk,
   input  logic                           srst,
   input  logic [IN_W-1:0]                din,
   input  logic                           wr_en,
   output logic                           full,
   output logic                           almost_full,
   input  logic                           rd_en,
   input  logic                           flush,
   output logic [OUT_W-1:0]               dout,
   output logic                           empty,
   output logic [$clog2(IN_W/OUT_W)-1:0]  slice_idx,
   output logic                           ovf_err,
   output logic                           udf_err
`ifdef MTRX_FIFO_FILLCNT_EN
  ,output logic [$clog2(DEPTH):0]         fill_cnt
`endif
);

   localparam int RATIO = calc_ratio(IN_W, OUT_W);
   localparam int SW    = idx_w(RATIO);
   localparam int PW    = idx_w(DEPTH);
   localparam int CW    = PW + 1;

   if (!cfg_legal(IN_W, OUT_W, DEPTH, AF_THRESH)) begin : g_cfg_err
      $error("mtrx_width_conv_fifo: illegal IN_W/OUT_W/DEPTH/AF_THRESH combination");
   end

   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_nxt;
   logic [SW-1:0]   slice_idx_q, slice_sel;
   logic            full_q, empty_q, af_q, ovf_q, udf_q;
   logic [IN_W-1:0] head_word;
   logic            wr_ok, last_slice, pop, adv;

   mtrx_dist_ram #(.DEPTH(DEPTH), .W(IN_W), .AW(PW)) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (head_word)
   );

   // Flush takes priority over rd_en; both are ignored when nothing is stored.
   always_comb begin
      wr_ok      = wr_en && !full_q;
      last_slice = (slice_idx_q == SW'(RATIO - 1));
      pop        = !empty_q && (flush || (rd_en && last_slice));
      adv        = !empty_q && !flush && rd_en && !last_slice;
      count_nxt  = count_q;
      if (wr_ok && !pop)      count_nxt = count_q + CW'(1);
      else if (!wr_ok && pop) count_nxt = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         slice_idx_q <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + PW'(1);
            slice_idx_q <= '0;
         end else if (adv) begin
            slice_idx_q <= slice_idx_q + SW'(1);
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
         af_q    <= (count_nxt >= CW'(AF_THRESH));
         if (wr_en && full_q) ovf_q <= 1'b1;
         if (rd_en && empty_q) udf_q <= 1'b1;
      end
   end

   // RATIO is a power of two, so reversing the slice order is a bitwise inversion.
   assign slice_sel = (MSB_FIRST != 0) ? ~slice_idx_q : slice_idx_q;

   assign dout        = empty_q ? '0 : head_word[int'(slice_sel) * OUT_W +: OUT_W];
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign slice_idx   = slice_idx_q;
   assign ovf_err     = ovf_q;
   assign udf_err     = udf_q;

`ifdef MTRX_FIFO_FILLCNT_EN
   assign fill_cnt = count_q;
`else
   // Count stays internal; only the derived flags are visible.
`endif

endmodule

// File: tb/tb_mtrx_width_conv_fifo.sv
// Directed bench for mtrx_width_conv_fifo: LSB-first instance plus an MSB_FIRST=1 instance.
module tb_mtrx_width_conv_fifo;

   logic        clk = 1'b0;
   logic        srst;
   logic [63:0] din;
   logic        wr_en, rd_en, flush;
   logic        full, almost_full, empty, ovf_err, udf_err;
   logic [7:0]  dout;
   logic [2:0]  slice_idx;

   logic [63:0] b_din;
   logic        b_wr_en, b_rd_en, b_flush;
   logic        b_full, b_almost_full, b_empty, b_ovf_err, b_udf_err;
   logic [7:0]  b_dout;
   logic [2:0]  b_slice_idx;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [63:0] W1 = 64'h0807060504030201;
   localparam logic [63:0] W2 = 64'h1817161514131211;
   localparam logic [63:0] WA = 64'hA7A6A5A4A3A2A1A0;
   localparam logic [63:0] WB = 64'hB7B6B5B4B3B2B1B0;

   always #5 clk = ~clk;

   mtrx_width_conv_fifo #(.IN_W(64), .OUT_W(8), .DEPTH(16), .AF_THRESH(14), .MSB_FIRST(0)) dut (
      .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .full(full),
      .almost_full(almost_full), .rd_en(rd_en), .flush(flush), .dout(dout),
      .empty(empty), .slice_idx(slice_idx), .ovf_err(ovf_err), .udf_err(udf_err)
   );

   mtrx_width_conv_fifo #(.IN_W(64), .OUT_W(8), .DEPTH(16), .AF_THRESH(14), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .srst(srst), .din(b_din), .wr_en(b_wr_en), .full(b_full),
      .almost_full(b_almost_full), .rd_en(b_rd_en), .flush(b_flush), .dout(b_dout),
      .empty(b_empty), .slice_idx(b_slice_idx), .ovf_err(b_ovf_err), .udf_err(b_udf_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [63:0] w);
      din = w; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic read_n(input int n);
      rd_en = 1'b1;
      repeat (n) tick();
      rd_en = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_empty"}, 64'(empty), 64'd1);
      chk({tag, "_full"},  64'(full), 64'd0);
      chk({tag, "_af"},    64'(almost_full), 64'd0);
      chk({tag, "_ovf"},   64'(ovf_err), 64'd0);
      chk({tag, "_udf"},   64'(udf_err), 64'd0);
      chk({tag, "_dout"},  64'(dout), 64'd0);
      chk({tag, "_idx"},   64'(slice_idx), 64'd0);
   endtask

   initial begin
      logic [7:0] b;
      srst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
      b_din = '0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0;
      tick(); tick();
      srst = 1'b0;
      chk_reset_state("rst");

      // 1: one word, eight reads, LSB slice first
      write_word(W1);
      chk("t1_empty_after_wr", 64'(empty), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_dout%0d", i), 64'(dout), 64'(i + 1));
         chk($sformatf("t1_idx%0d", i), 64'(slice_idx), 64'(i));
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      chk("t1_empty_end", 64'(empty), 64'd1);
      chk("t1_dout_end", 64'(dout), 64'd0);

      // 2: fill to full, overflow, drain and confirm contents
      for (int k = 1; k <= 16; k++) begin
         b = 8'h10 + 8'(k);
         write_word({8{b}});
         chk($sformatf("t2_af_k%0d", k), 64'(almost_full), 64'(k >= 14));
         chk($sformatf("t2_full_k%0d", k), 64'(full), 64'(k == 16));
      end
      write_word(64'hDEADBEEFDEADBEEF);
      chk("t2_ovf", 64'(ovf_err), 64'd1);
      chk("t2_full_kept", 64'(full), 64'd1);
      chk("t2_head", 64'(dout), 64'h11);
      for (int k = 1; k <= 16; k++) begin
         b = 8'h10 + 8'(k);
         chk($sformatf("t2_word%0d", k), 64'(dout), 64'(b));
         read_n(8);
      end
      chk("t2_empty_drained", 64'(empty), 64'd1);
      chk("t2_af_drained", 64'(almost_full), 64'd0);

      // 3: simultaneous write and final-slice read with one word stored
      write_word(W1);
      read_n(7);
      chk("t3_idx7", 64'(slice_idx), 64'd7);
      chk("t3_dout08", 64'(dout), 64'h08);
      din = W2; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("t3_empty", 64'(empty), 64'd0);
      chk("t3_idx0", 64'(slice_idx), 64'd0);
      chk("t3_dout11", 64'(dout), 64'h11);
      read_n(7);
      chk("t3_one_word_left", 64'(empty), 64'd0);
      read_n(1);
      chk("t3_count1", 64'(empty), 64'd1);

      // 4: flush mid-word (with rd_en asserted), then flush on empty
      write_word(WA);
      write_word(WB);
      read_n(3);
      chk("t4_dout_a3", 64'(dout), 64'hA3);
      flush = 1'b1; rd_en = 1'b1; tick(); flush = 1'b0; rd_en = 1'b0;
      chk("t4_dout_b0", 64'(dout), 64'hB0);
      chk("t4_idx0", 64'(slice_idx), 64'd0);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t4_empty_b_flushed", 64'(empty), 64'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t4_flush_empty_udf", 64'(udf_err), 64'd0);
      chk("t4_flush_empty_idx", 64'(slice_idx), 64'd0);
      chk("t4_flush_empty_e", 64'(empty), 64'd1);

      // 5: underflow, pointers hold, reset mid-word
      read_n(1);
      chk("t5_udf", 64'(udf_err), 64'd1);
      chk("t5_udf_empty", 64'(empty), 64'd1);
      chk("t5_udf_idx", 64'(slice_idx), 64'd0);
      write_word(W1);
      chk("t5_ptr_hold", 64'(dout), 64'h01);
      write_word(W2);
      read_n(5);
      chk("t5_dout06", 64'(dout), 64'h06);
      chk("t5_idx5", 64'(slice_idx), 64'd5);
      srst = 1'b1; tick(); srst = 1'b0;
      chk_reset_state("t5_rst");

      // 6: MSB-first slice order
      b_din = W1; b_wr_en = 1'b1; tick(); b_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t6_dout%0d", i), 64'(b_dout), 64'(8 - i));
         chk($sformatf("t6_idx%0d", i), 64'(b_slice_idx), 64'(i));
         b_rd_en = 1'b1; tick(); b_rd_en = 1'b0;
      end
      chk("t6_empty", 64'(b_empty), 64'd1);
      chk("t6_flags", {60'd0, b_full, b_almost_full, b_ovf_err, b_udf_err}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
